// File: rtl/pc_tick_controller.sv
// rtl/pc_tick_controller.sv - programmable processor tick generator with run/step/wait sequencing
// All outputs are registered; the tick for a STEP is issued in the STEP cycle itself.
module pc_tick_controller #(
    parameter int CNT_W       = 20,
    parameter int DIV_DEFAULT = 999999,
    parameter int WAIT_W      = 16
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              div_load,
    output logic              div_ack,
    input  logic              wait_req,
    input  logic [WAIT_W-1:0] wait_len,
    output logic              wait_busy,
    output logic              wait_done,
    output logic              pc_tick,
    output logic [1:0]        state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_cur_q, div_cur_d;
    logic [CNT_W-1:0]  div_pend_q, div_pend_d;
    logic              pend_q, pend_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              tick_q, tick_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              counting;
    logic              itk;
    logic              apply;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DIV_RST;
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            wait_cnt_q <= '0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            wait_cnt_q <= wait_cnt_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        wait_cnt_d = wait_cnt_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        done_d     = 1'b0;

        counting = (state_q == ST_RUN) || (state_q == ST_WAIT);
        itk      = counting && (cnt_q == div_cur_q);
        if (counting) begin
            cnt_d = itk ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (wait_req) begin
                    if (wait_len != '0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = wait_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (wait_req && (wait_len != '0)) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_len;
                    cnt_d      = '0;
                end else if (wait_req) begin
                    done_d = 1'b1;
                    tick_d = itk;
                end else if (!run) begin
                    // Dropping run swallows a tick that would land in the first IDLE cycle.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    tick_d = itk;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (itk) begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = run ? ST_RUN : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_STEP) begin
            tick_d = 1'b1;
        end

        // A new divisor only takes effect on a period boundary so cnt never passes div_cur.
        apply = pend_q && (itk || !counting);
        if (apply) begin
            div_cur_d = div_pend_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end
        if (div_load) begin
            div_pend_d = (div_val == '0) ? CNT_W'(1) : div_val;
            pend_d     = 1'b1;
        end

        busy_d = (state_d == ST_WAIT);
    end

    assign pc_tick   = tick_q;
    assign div_ack   = ack_q;
    assign wait_done = done_q;
    assign wait_busy = busy_q;
    assign state_o   = state_q;
endmodule

// File: tb/tb_pc_tick_controller.sv
// tb/tb_pc_tick_controller.sv - self-checking bench for pc_tick_controller
module tb_pc_tick_controller;
    localparam int CNT_W  = 20;
    localparam int WAIT_W = 16;
    localparam int DIVD   = 9;

    logic              clk_100m = 1'b0;
    logic              rst;
    logic              run;
    logic              step;
    logic [CNT_W-1:0]  div_val;
    logic              div_load;
    logic              div_ack;
    logic              wait_req;
    logic [WAIT_W-1:0] wait_len;
    logic              wait_busy;
    logic              wait_done;
    logic              pc_tick;
    logic [1:0]        state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_div;

    always #5 clk_100m = ~clk_100m;

    pc_tick_controller #(.CNT_W(CNT_W), .DIV_DEFAULT(DIVD), .WAIT_W(WAIT_W)) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .run      (run),
        .step     (step),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .wait_req (wait_req),
        .wait_len (wait_len),
        .wait_busy(wait_busy),
        .wait_done(wait_done),
        .pc_tick  (pc_tick),
        .state_o  (state_o)
    );

    task automatic nxt();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; div_load = 1'b0; div_val = '0;
        wait_req = 1'b0; wait_len = '0;
        repeat (3) nxt();
        rst = 1'b0;
        nxt();
        n_cmp++; if (pc_tick !== 1'b0) begin n_bad++; $display("FAIL reset_pc_tick got %b want 0", pc_tick); end
        n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL reset_div_ack got %b want 0", div_ack); end
        n_cmp++; if (wait_busy !== 1'b0) begin n_bad++; $display("FAIL reset_wait_busy got %b want 0", wait_busy); end
        n_cmp++; if (wait_done !== 1'b0) begin n_bad++; $display("FAIL reset_wait_done got %b want 0", wait_done); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state_o); end
        cur_div = DIVD;
    endtask

    // Free run from IDLE, random step noise, run dropped at cycle r.
    task automatic test_run(input int r);
        int  d;
        logic exp_t;
        logic [1:0] exp_s;
        d = cur_div;
        run = 1'b1;
        for (int rel = 1; rel <= r + d + 3; rel++) begin
            nxt();
            exp_t = (rel >= d + 2) && (rel <= r) && (((rel - d - 2) % (d + 1)) == 0);
            exp_s = (rel <= r) ? 2'd1 : 2'd0;
            n_cmp++; if (pc_tick !== exp_t) begin n_bad++; $display("FAIL run_tick rel=%0d d=%0d got %b want %b", rel, d, pc_tick, exp_t); end
            n_cmp++; if (state_o !== exp_s) begin n_bad++; $display("FAIL run_state rel=%0d got %0d want %0d", rel, state_o, exp_s); end
            step = (rel < r) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (rel == r) run = 1'b0;
        end
        step = 1'b0;
        run  = 1'b0;
    endtask

    // Random step pattern in IDLE: a step is honoured only when not already in a step cycle.
    task automatic test_step();
        logic sbit, exp_t, last_t;
        last_t = 1'b0;
        sbit = $urandom_range(0, 1) == 1;
        step = sbit;
        for (int c = 0; c < 40; c++) begin
            nxt();
            exp_t = sbit && !last_t;
            n_cmp++; if (pc_tick !== exp_t) begin n_bad++; $display("FAIL step_tick c=%0d got %b want %b", c, pc_tick, exp_t); end
            n_cmp++; if (state_o !== (exp_t ? 2'd2 : 2'd0)) begin n_bad++; $display("FAIL step_state c=%0d got %0d want %0d", c, state_o, exp_t ? 2 : 0); end
            last_t = exp_t;
            sbit = (c < 37) ? ($urandom_range(0, 1) == 1) : 1'b0;
            step = sbit;
        end
        step = 1'b0;
        nxt(); nxt();
    endtask

    task automatic test_div_idle(input int v);
        div_val = CNT_W'(v);
        div_load = 1'b1;
        nxt();
        div_load = 1'b0;
        for (int rel = 1; rel <= 5; rel++) begin
            n_cmp++; if (div_ack !== (rel == 2)) begin n_bad++; $display("FAIL idle_ack rel=%0d got %b want %b", rel, div_ack, rel == 2); end
            n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL idle_ack_state rel=%0d got %0d want 0", rel, state_o); end
            nxt();
        end
        cur_div = (v == 0) ? 1 : v;
    endtask

    // Double load mid-period (last wins), then a load coincident with the wrap that applies it.
    task automatic test_div_change();
        int d0, p0, p1, p2, d1, d2, v1, v2, l1, w, last;
        logic exp_t, exp_a;
        d0 = cur_div; p0 = d0 + 1;
        v1 = $urandom_range(0, 6); v2 = $urandom_range(0, 6);
        d1 = (v1 == 0) ? 1 : v1;   d2 = (v2 == 0) ? 1 : v2;
        p1 = d1 + 1; p2 = d2 + 1;
        l1 = 3 + p0;
        w = 2 * p0;
        last = w + 1 + p1 + 3 * p2;
        run = 1'b1;
        for (int rel = 1; rel <= last; rel++) begin
            nxt();
            exp_a = (rel == w + 1) || (rel == w + 1 + p1);
            exp_t = (rel >= d0 + 2 && rel <= w + 1 && ((rel - d0 - 2) % p0) == 0) ||
                    (rel == w + 1 + p1) ||
                    (rel > w + 1 + p1 && ((rel - w - 1 - p1) % p2) == 0);
            n_cmp++; if (div_ack !== exp_a) begin n_bad++; $display("FAIL chg_ack rel=%0d got %b want %b", rel, div_ack, exp_a); end
            n_cmp++; if (pc_tick !== exp_t) begin n_bad++; $display("FAIL chg_tick rel=%0d got %b want %b", rel, pc_tick, exp_t); end
            div_load = (rel == l1) || (rel == l1 + 1) || (rel == w);
            if (rel == l1)          div_val = CNT_W'($urandom_range(0, 6));
            else if (rel == l1 + 1) div_val = CNT_W'(v1);
            else if (rel == w)      div_val = CNT_W'(v2);
        end
        div_load = 1'b0;
        run = 1'b0;
        nxt(); nxt();
        cur_div = d2;
    endtask

    task automatic test_wait(input bit keep_run, input int len);
        int d, w, dn, last;
        logic exp_t, exp_b, exp_dn;
        logic [1:0] exp_s;
        d = cur_div;
        w = d + 2 + $urandom_range(0, d);
        dn = w + len * (d + 1) + 1;
        last = dn + 3 * (d + 1) + 2;
        run = 1'b1;
        for (int rel = 1; rel <= last; rel++) begin
            nxt();
            exp_b  = (rel > w) && (rel < dn);
            exp_dn = (rel == dn);
            exp_t  = (rel >= d + 2 && rel <= w && ((rel - d - 2) % (d + 1)) == 0) ||
                     (keep_run && rel >= dn + d + 1 && ((rel - dn - d - 1) % (d + 1)) == 0);
            exp_s  = exp_b ? 2'd3 : ((rel <= w || keep_run) ? 2'd1 : 2'd0);
            n_cmp++; if (pc_tick !== exp_t) begin n_bad++; $display("FAIL wait_tick rel=%0d got %b want %b", rel, pc_tick, exp_t); end
            n_cmp++; if (wait_busy !== exp_b) begin n_bad++; $display("FAIL wait_busy rel=%0d got %b want %b", rel, wait_busy, exp_b); end
            n_cmp++; if (wait_done !== exp_dn) begin n_bad++; $display("FAIL wait_done rel=%0d got %b want %b", rel, wait_done, exp_dn); end
            n_cmp++; if (state_o !== exp_s) begin n_bad++; $display("FAIL wait_state rel=%0d got %0d want %0d", rel, state_o, exp_s); end
            wait_req = (rel == w) || (rel == w + 3 && rel + 1 < dn);
            wait_len = (rel == w) ? WAIT_W'(len) : WAIT_W'($urandom_range(1, 5));
            step = (rel == w + 2) && (rel + 1 < dn);
            if (!keep_run && rel == w + 1) run = 1'b0;
        end
        wait_req = 1'b0; step = 1'b0; run = 1'b0;
        nxt(); nxt();
    endtask

    task automatic test_wait_zero();
        int d, w;
        logic exp_t;
        d = cur_div;
        wait_req = 1'b1; wait_len = '0;
        for (int rel = 1; rel <= 4; rel++) begin
            nxt();
            wait_req = 1'b0;
            n_cmp++; if (wait_done !== (rel == 1)) begin n_bad++; $display("FAIL wz_idle_done rel=%0d got %b want %b", rel, wait_done, rel == 1); end
            n_cmp++; if (wait_busy !== 1'b0) begin n_bad++; $display("FAIL wz_idle_busy rel=%0d got %b want 0", rel, wait_busy); end
            n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL wz_idle_state rel=%0d got %0d want 0", rel, state_o); end
        end
        w = d + 3;
        run = 1'b1;
        for (int rel = 1; rel <= w + 3 * (d + 1); rel++) begin
            nxt();
            exp_t = (rel >= d + 2) && (((rel - d - 2) % (d + 1)) == 0);
            n_cmp++; if (pc_tick !== exp_t) begin n_bad++; $display("FAIL wz_run_tick rel=%0d got %b want %b", rel, pc_tick, exp_t); end
            n_cmp++; if (wait_done !== (rel == w + 1)) begin n_bad++; $display("FAIL wz_run_done rel=%0d got %b want %b", rel, wait_done, rel == w + 1); end
            n_cmp++; if (wait_busy !== 1'b0) begin n_bad++; $display("FAIL wz_run_busy rel=%0d got %b want 0", rel, wait_busy); end
            wait_req = (rel == w);
        end
        wait_req = 1'b0; run = 1'b0;
        nxt(); nxt();
    endtask

    task automatic test_reset_midwait();
        int d;
        d = cur_div;
        run = 1'b1;
        repeat (d + 4) nxt();
        wait_req = 1'b1; wait_len = WAIT_W'(4);
        nxt();
        wait_req = 1'b0;
        repeat (3) nxt();
        n_cmp++; if (wait_busy !== 1'b1) begin n_bad++; $display("FAIL rmw_busy_before got %b want 1", wait_busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pc_tick !== 1'b0) begin n_bad++; $display("FAIL rmw_pc_tick got %b want 0", pc_tick); end
        n_cmp++; if (wait_busy !== 1'b0) begin n_bad++; $display("FAIL rmw_wait_busy got %b want 0", wait_busy); end
        n_cmp++; if (wait_done !== 1'b0) begin n_bad++; $display("FAIL rmw_wait_done got %b want 0", wait_done); end
        n_cmp++; if (div_ack !== 1'b0) begin n_bad++; $display("FAIL rmw_div_ack got %b want 0", div_ack); end
        n_cmp++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL rmw_state got %0d want 0", state_o); end
        run = 1'b0;
        nxt(); nxt();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            nxt();
            n_cmp++; if (wait_done !== 1'b0 || wait_busy !== 1'b0 || state_o !== 2'd0) begin
                n_bad++; $display("FAIL rmw_after c=%0d done=%b busy=%b state=%0d want 0/0/0", c, wait_done, wait_busy, state_o);
            end
        end
        cur_div = DIVD;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run(3 * (DIVD + 1) + 1);
        test_step();
        test_div_change();
        test_run(4 * (cur_div + 1) + $urandom_range(0, cur_div));
        test_div_idle(4);
        test_wait(1'b1, 3);
        test_wait(1'b0, $urandom_range(1, 3));
        test_div_idle(0);
        test_run(5 * (cur_div + 1) + $urandom_range(0, 1));
        test_wait_zero();
        test_div_idle($urandom_range(2, 7));
        test_wait(1'b1, $urandom_range(1, 3));
        test_reset_midwait();
        test_run(2 * (DIVD + 1) + 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
